// File: rtl/win_banner_pkg.sv
// Shared types and constant tables for the end-of-game "P<n>" banner renderer.
package win_banner_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REVEAL,
    S_HOLD
  } state_t;

  localparam int BANNER_COLS = 7;
  localparam int BANNER_ROWS = 5;

  // Colours are packed {R,G,B}, 4 bits each
  localparam logic [11:0] RGB_BLACK = 12'h000;
  localparam logic [11:0] RGB_GRAY  = 12'h333;
  localparam logic [11:0] RGB_WHITE = 12'hFFF;

  // Element [0] is player 0 (green), then blue, red, yellow
  localparam logic [3:0][11:0] PLAYER_COLOUR = {12'hFF0, 12'hF00, 12'h00F, 12'h0F0};

  // GLYPH_ROM[glyph][row], glyph 0 = 'P', 1..4 = digits; row 0 is the top row, bit 2 the leftmost column
  localparam logic [4:0][4:0][2:0] GLYPH_ROM = {
    {3'b001, 3'b001, 3'b111, 3'b101, 3'b101},
    {3'b111, 3'b001, 3'b111, 3'b001, 3'b111},
    {3'b111, 3'b100, 3'b111, 3'b001, 3'b111},
    {3'b111, 3'b010, 3'b010, 3'b110, 3'b010},
    {3'b100, 3'b100, 3'b111, 3'b101, 3'b111}
  };

endpackage

// File: rtl/win_banner_renderer_if.sv
// Pixel-path bundle between the VGA counters / game controller and the banner renderer.
interface win_banner_renderer_if #(
  parameter int N_PLAYERS = 2
) ();
  localparam int WW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

  logic [15:0]   H_Counter_Value;
  logic [15:0]   V_Counter_Value;
  logic          show;
  logic [WW-1:0] winner;
  logic [3:0]    Red;
  logic [3:0]    Green;
  logic [3:0]    Blue;
  logic          done;

  modport master (
    output H_Counter_Value, V_Counter_Value, show, winner,
    input  Red, Green, Blue, done
  );

  modport slave (
    input  H_Counter_Value, V_Counter_Value, show, winner,
    output Red, Green, Blue, done
  );
endinterface

// File: rtl/win_glyph_rom.sv
// Combinational glyph bitmap lookup: one 3-bit row of the 'P' or a digit glyph.
module win_glyph_rom
  import win_banner_pkg::*;
(
  input  logic [2:0] glyph,
  input  logic [2:0] row,
  output logic [2:0] row_bits
);

  always_comb begin
    row_bits = 3'b000;
    if (glyph < 3'd5 && row < 3'd5) begin
      row_bits = GLYPH_ROM[glyph][row];
    end
  end

endmodule

// File: rtl/win_banner_renderer.sv
// Win banner renderer: column-by-column reveal of "P<n>" on a gray field, one column per frame.
// Define WIN_BLINK_EN to make the fully revealed banner blink between player colour and white.
module win_banner_renderer
  import win_banner_pkg::*;
#(
  parameter int N_PLAYERS    = 2,
  parameter int CELL_LOG2    = 6,
  parameter int BANNER_X0    = 240,
  parameter int BANNER_Y0    = 115,
  parameter int H_ACT_START  = 144,
  parameter int H_ACT_END    = 783,
  parameter int V_ACT_START  = 35,
  parameter int V_ACT_END    = 514,
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  win_banner_renderer_if.slave bus
);

  localparam int WW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam logic [15:0] X0_W  = 16'(BANNER_X0);
  localparam logic [15:0] Y0_W  = 16'(BANNER_Y0);
  localparam logic [15:0] HS_W  = 16'(H_ACT_START);
  localparam logic [15:0] HE_W  = 16'(H_ACT_END);
  localparam logic [15:0] VS_W  = 16'(V_ACT_START);
  localparam logic [15:0] VE_W  = 16'(V_ACT_END);
  localparam logic [WW-1:0] WMAX = WW'(N_PLAYERS - 1);

  state_t        state_q, state_d;
  logic [2:0]    reveal_q, reveal_d;
  logic [WW-1:0] winner_q, winner_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          done_q, done_d;
`ifdef WIN_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
`endif

  logic          fs;
  logic          active;
  logic          in_banner;
  logic [15:0]   dx, dy, col_w, row_w;
  logic [2:0]    col, row, glyph_sel, row_bits;
  logic [1:0]    bit_pos;
  logic          lit;
  logic [11:0]   glyph_rgb;

  assign fs     = (bus.H_Counter_Value == 16'd0) && (bus.V_Counter_Value == 16'd0);
  assign active = (bus.H_Counter_Value >= HS_W) && (bus.H_Counter_Value <= HE_W) &&
                  (bus.V_Counter_Value >= VS_W) && (bus.V_Counter_Value <= VE_W);

  // Cell coordinates; the wrapped difference is only meaningful when at or past the banner origin
  assign dx        = bus.H_Counter_Value - X0_W;
  assign dy        = bus.V_Counter_Value - Y0_W;
  assign col_w     = dx >> CELL_LOG2;
  assign row_w     = dy >> CELL_LOG2;
  assign in_banner = (bus.H_Counter_Value >= X0_W) && (bus.V_Counter_Value >= Y0_W) &&
                     (col_w < 16'(BANNER_COLS)) && (row_w < 16'(BANNER_ROWS));
  assign col       = col_w[2:0];
  assign row       = row_w[2:0];

  assign glyph_sel = (col < 3'd3) ? 3'd0 : (3'(winner_q) + 3'd1);
  assign bit_pos   = (col < 3'd3) ? 2'(3'd2 - col) : 2'(3'd6 - col);

  win_glyph_rom u_rom (
    .glyph    (glyph_sel),
    .row      (row),
    .row_bits (row_bits)
  );

  assign lit = in_banner && (col != 3'd3) && row_bits[bit_pos];

`ifdef WIN_BLINK_EN
  assign glyph_rgb = blink_phase_q ? RGB_WHITE : PLAYER_COLOUR[winner_q];
`else
  assign glyph_rgb = PLAYER_COLOUR[winner_q];
`endif

  always_comb begin
    state_d  = state_q;
    reveal_d = reveal_q;
    winner_d = winner_q;
`ifdef WIN_BLINK_EN
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
`endif
    if (fs) begin
      case (state_q)
        S_IDLE: begin
          if (bus.show) begin
            winner_d = (bus.winner > WMAX) ? WMAX : bus.winner;
            reveal_d = 3'd1;
            state_d  = S_REVEAL;
          end
        end
        default: begin
          // Dropping show wins over any reveal or blink progress
          if (!bus.show) begin
            state_d  = S_IDLE;
            reveal_d = 3'd0;
`ifdef WIN_BLINK_EN
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
`endif
          end else if (state_q == S_REVEAL) begin
            reveal_d = reveal_q + 3'd1;
            if (reveal_q == 3'(BANNER_COLS - 1)) begin
              state_d = S_HOLD;
`ifdef WIN_BLINK_EN
              blink_cnt_d   = '0;
              blink_phase_d = 1'b0;
`endif
            end
          end else begin
`ifdef WIN_BLINK_EN
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
              blink_cnt_d   = '0;
              blink_phase_d = ~blink_phase_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 1'b1;
            end
`endif
          end
        end
      endcase
    end

    if (!active) begin
      rgb_d = RGB_BLACK;
    end else if (lit && (col < reveal_q)) begin
      rgb_d = glyph_rgb;
    end else begin
      rgb_d = RGB_GRAY;
    end
    done_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      reveal_q <= 3'd0;
      winner_q <= '0;
      rgb_q    <= RGB_BLACK;
      done_q   <= 1'b0;
`ifdef WIN_BLINK_EN
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      reveal_q <= reveal_d;
      winner_q <= winner_d;
      rgb_q    <= rgb_d;
      done_q   <= done_d;
`ifdef WIN_BLINK_EN
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
`endif
    end
  end

  assign bus.Red   = rgb_q[11:8];
  assign bus.Green = rgb_q[7:4];
  assign bus.Blue  = rgb_q[3:0];
  assign bus.done  = done_q;

endmodule

// File: tb/tb_win_banner_renderer.sv
// Directed bench for win_banner_renderer: reset, blanking, reveal, boundaries, winner latch, mid-run reset.
module tb_win_banner_renderer;

  logic clk = 1'b0;
  logic rst;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  win_banner_renderer_if #(.N_PLAYERS(2)) bus_if ();

  win_banner_renderer #(.N_PLAYERS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one pixel, step one clock, check the registered colour
  task automatic pix(input string tag, input int h, input int v, input logic [11:0] exp);
    bus_if.H_Counter_Value = 16'(h);
    bus_if.V_Counter_Value = 16'(v);
    @(posedge clk);
    #1;
    chk(tag, {bus_if.Red, bus_if.Green, bus_if.Blue}, exp);
    $display("pix %-14s H=%0d V=%0d rgb=%h done=%b", tag, h, v,
             {bus_if.Red, bus_if.Green, bus_if.Blue}, bus_if.done);
  endtask

  task automatic frame();
    bus_if.H_Counter_Value = 16'd0;
    bus_if.V_Counter_Value = 16'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_done(input string tag, input logic exp);
    chk(tag, {11'b0, bus_if.done}, {11'b0, exp});
  endtask

  initial begin
    rst = 1'b1;
    bus_if.show = 1'b0;
    bus_if.winner = 1'b0;
    for (int i = 0; i < 3; i++) pix("reset_rgb", 256, 131, 12'h000);
    chk_done("reset_done", 1'b0);
    rst = 1'b0;
    pix("post_reset", 256, 131, 12'h333);
    chk_done("idle_done", 1'b0);
    pix("blank_idle", 100, 200, 12'h000);

    // Reveal for player 0 (green)
    bus_if.show = 1'b1;
    frame();
    pix("rev1_col0", 256, 131, 12'h0F0);
    pix("rev1_col5", 576, 131, 12'h333);
    for (int i = 0; i < 5; i++) frame();
    pix("rev6_col5", 576, 131, 12'h0F0);
    chk_done("rev6_done", 1'b0);
    frame();
    chk_done("rev7_done", 1'b1);
    pix("hold_col5", 576, 131, 12'h0F0);
    pix("hold_unlit", 512, 131, 12'h333);
    pix("gap_col3", 448, 131, 12'h333);
    pix("right_edge", 783, 131, 12'h333);
    pix("h_past_act", 784, 131, 12'h000);
    pix("left_of_x0", 239, 131, 12'h333);
    pix("last_row", 240, 434, 12'h0F0);
    pix("below_rows", 240, 435, 12'h333);
    pix("blank_hold", 100, 200, 12'h000);

`ifdef WIN_BLINK_EN
    for (int i = 0; i < 29; i++) frame();
    pix("blink29", 256, 131, 12'h0F0);
    frame();
    pix("blink30", 256, 131, 12'hFFF);
    for (int i = 0; i < 30; i++) frame();
    pix("blink60", 256, 131, 12'h0F0);
`endif

    bus_if.show = 1'b0;
    frame();
    pix("idle_again", 256, 131, 12'h333);
    chk_done("idle_done2", 1'b0);

    // Player 1 (blue, "P2"); winner changes after entry must be ignored
    bus_if.show = 1'b1;
    bus_if.winner = 1'b1;
    for (int i = 0; i < 7; i++) frame();
    chk_done("p2_done", 1'b1);
    pix("p2_col4", 512, 131, 12'h00F);
    pix("p2_r1_col4", 512, 179, 12'h333);
    pix("p2_r1_col6", 640, 179, 12'h00F);
    bus_if.winner = 1'b0;
    frame();
    pix("winner_held", 256, 131, 12'h00F);
    bus_if.show = 1'b0;
    frame();
    pix("p2_idle", 256, 131, 12'h333);

    // Reset in the middle of a reveal
    bus_if.show = 1'b1;
    for (int i = 0; i < 4; i++) frame();
    pix("mid_col3", 448, 131, 12'h333);
    pix("mid_col0", 256, 131, 12'h0F0);
    rst = 1'b1;
    pix("mid_rst", 256, 131, 12'h000);
    rst = 1'b0;
    bus_if.show = 1'b0;
    pix("after_rst", 256, 131, 12'h333);
    chk_done("after_rst_done", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
